// File: rtl/hazard_ctrl.sv
// ============================================================================
// hazard_ctrl : 5-stage pipeline sequencing (load-use, flush, memory wait/halt)
// Revision    : 1.0
// ============================================================================
`default_nettype none

module hazard_ctrl #(
   parameter int MEM_TIMEOUT = 255
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        IDEX_MemRead_i,
   input  logic [4:0]  IDEX_Rt_i,
   input  logic [4:0]  IFID_Rs_i,
   input  logic [4:0]  IFID_Rt_i,
   input  logic        Branch_i,
   input  logic        Jump_i,
   input  logic        MemReq_i,
   input  logic        MemReady_i,
   output logic        PCWrite_o,
   output logic        IFIDWrite_o,
   output logic        IFFlush_o,
   output logic        Bubble_o,
   output logic        PipeWrite_o,
   output logic        Timeout_o,
   output logic [15:0] StallCnt_o,
   output logic [15:0] FlushCnt_o
);

   localparam logic [1:0] S_RUN      = 2'd0;
   localparam logic [1:0] S_MEM_WAIT = 2'd1;
   localparam logic [1:0] S_HALT     = 2'd2;

   localparam logic [7:0] WAIT_LAST  = 8'(MEM_TIMEOUT - 1);
   localparam logic [15:0] CNT_MAX   = 16'hFFFF;

   logic [1:0]  state_q, state_d;
   logic [7:0]  wait_cnt_q, wait_cnt_d;
   logic [15:0] stall_cnt_q, stall_cnt_d;
   logic [15:0] flush_cnt_q, flush_cnt_d;

   logic lu, miss, freeze;

   // Register 0 is hardwired, so a load targeting it never creates a dependency.
   assign lu     = IDEX_MemRead_i && (IDEX_Rt_i != 5'd0) &&
                   ((IDEX_Rt_i == IFID_Rs_i) || (IDEX_Rt_i == IFID_Rt_i));
   assign miss   = MemReq_i && !MemReady_i;
   assign freeze = ((state_q == S_RUN) && miss) ||
                   ((state_q == S_MEM_WAIT) && !MemReady_i);

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q     <= S_RUN;
         wait_cnt_q  <= 8'd0;
         stall_cnt_q <= 16'd0;
         flush_cnt_q <= 16'd0;
      end else begin
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      case (state_q)
         S_RUN: begin
            if (miss) begin
               state_d    = S_MEM_WAIT;
               wait_cnt_d = 8'd0;
            end
         end
         S_MEM_WAIT: begin
            if (MemReady_i) begin
               state_d = S_RUN;
            end else if (wait_cnt_q == WAIT_LAST) begin
               state_d = S_HALT;
            end else begin
               wait_cnt_d = wait_cnt_q + 8'd1;
            end
         end
         S_HALT:  state_d = S_HALT;
         default: state_d = S_RUN;
      endcase
   end

   always_comb begin
      PCWrite_o   = 1'b0;
      IFIDWrite_o = 1'b0;
      IFFlush_o   = 1'b0;
      Bubble_o    = 1'b0;
      PipeWrite_o = 1'b0;
      Timeout_o   = 1'b0;
      if (!rst_n_i) begin
         Timeout_o = 1'b0;
      end else if (state_q == S_HALT) begin
         Timeout_o = 1'b1;
      end else if (freeze) begin
         Timeout_o = 1'b0;
      end else if (lu) begin
         // Branch operands depend on the load, so the branch is retried next cycle.
         Bubble_o    = 1'b1;
         PipeWrite_o = 1'b1;
      end else if (Branch_i || Jump_i) begin
         PCWrite_o   = 1'b1;
         IFIDWrite_o = 1'b1;
         IFFlush_o   = 1'b1;
         PipeWrite_o = 1'b1;
      end else begin
         PCWrite_o   = 1'b1;
         IFIDWrite_o = 1'b1;
         PipeWrite_o = 1'b1;
      end
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (!PCWrite_o && (stall_cnt_q != CNT_MAX)) begin
         stall_cnt_d = stall_cnt_q + 16'd1;
      end
      if (IFFlush_o && (flush_cnt_q != CNT_MAX)) begin
         flush_cnt_d = flush_cnt_q + 16'd1;
      end
   end

   assign StallCnt_o = stall_cnt_q;
   assign FlushCnt_o = flush_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// ============================================================================
// tb_hazard_ctrl : randomized + directed check of hazard_ctrl against a model
// Revision       : 1.0
// ============================================================================
`default_nettype none

module tb_hazard_ctrl;

   logic       clk_i = 1'b0;
   logic       rst_n_i;
   logic       memread, br, jmp, req, rdy;
   logic [4:0] idrt, rs, rt;

   wire [5:0]  ctl0, ctl1;
   wire [15:0] sc0, fc0, sc1, fc1;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk_i = ~clk_i;

   hazard_ctrl #(.MEM_TIMEOUT(255)) u_dut_t255 (
      .clk_i(clk_i), .rst_n_i(rst_n_i),
      .IDEX_MemRead_i(memread), .IDEX_Rt_i(idrt), .IFID_Rs_i(rs), .IFID_Rt_i(rt),
      .Branch_i(br), .Jump_i(jmp), .MemReq_i(req), .MemReady_i(rdy),
      .PCWrite_o(ctl0[5]), .IFIDWrite_o(ctl0[4]), .IFFlush_o(ctl0[3]),
      .Bubble_o(ctl0[2]), .PipeWrite_o(ctl0[1]), .Timeout_o(ctl0[0]),
      .StallCnt_o(sc0), .FlushCnt_o(fc0)
   );

   hazard_ctrl #(.MEM_TIMEOUT(3)) u_dut_t3 (
      .clk_i(clk_i), .rst_n_i(rst_n_i),
      .IDEX_MemRead_i(memread), .IDEX_Rt_i(idrt), .IFID_Rs_i(rs), .IFID_Rt_i(rt),
      .Branch_i(br), .Jump_i(jmp), .MemReq_i(req), .MemReady_i(rdy),
      .PCWrite_o(ctl1[5]), .IFIDWrite_o(ctl1[4]), .IFFlush_o(ctl1[3]),
      .Bubble_o(ctl1[2]), .PipeWrite_o(ctl1[1]), .Timeout_o(ctl1[0]),
      .StallCnt_o(sc1), .FlushCnt_o(fc1)
   );

   // Reference model: per instance, a halted flag, a waiting flag and the run
   // length of not-ready cycles seen while waiting.
   int       tmo     [2] = '{255, 3};
   bit       halted  [2];
   bit       waiting [2];
   int       nready  [2];
   int       stall_m [2];
   int       flush_m [2];
   logic [5:0] exp_ctl [2];

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %h expected %h", tag, $time, obs, exp);
      end
   endtask

   // Bits: {PCWrite, IFIDWrite, IFFlush, Bubble, PipeWrite, Timeout}
   function automatic logic [5:0] model_ctl(input int k);
      bit lu, miss, frz;
      lu   = memread && (idrt != 0) && (idrt == rs || idrt == rt);
      miss = req && !rdy;
      frz  = waiting[k] ? !rdy : miss;
      if (!rst_n_i)       return 6'b000000;
      if (halted[k])      return 6'b000001;
      if (frz)            return 6'b000000;
      if (lu)             return 6'b000110;
      if (br || jmp)      return 6'b111010;
      return 6'b110010;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         halted[k] = 0; waiting[k] = 0; nready[k] = 0;
         stall_m[k] = 0; flush_m[k] = 0;
      end
   endtask

   task automatic model_tick();
      if (!rst_n_i) return;
      for (int k = 0; k < 2; k++) begin
         if (!exp_ctl[k][5]) stall_m[k] = (stall_m[k] < 65535) ? stall_m[k] + 1 : 65535;
         if (exp_ctl[k][3])  flush_m[k] = (flush_m[k] < 65535) ? flush_m[k] + 1 : 65535;
         if (halted[k]) begin
         end else if (waiting[k]) begin
            if (rdy) waiting[k] = 0;
            else begin
               nready[k]++;
               if (nready[k] == tmo[k]) halted[k] = 1;
            end
         end else if (req && !rdy) begin
            waiting[k] = 1;
            nready[k]  = 0;
         end
      end
   endtask

   task automatic check_all();
      exp_ctl[0] = model_ctl(0);
      exp_ctl[1] = model_ctl(1);
      chk("ctl_t255",   {10'd0, ctl0}, {10'd0, exp_ctl[0]});
      chk("stall_t255", sc0, 16'(stall_m[0]));
      chk("flush_t255", fc0, 16'(flush_m[0]));
      chk("ctl_t3",     {10'd0, ctl1}, {10'd0, exp_ctl[1]});
      chk("stall_t3",   sc1, 16'(stall_m[1]));
      chk("flush_t3",   fc1, 16'(flush_m[1]));
   endtask

   task automatic step();
      @(negedge clk_i);
      check_all();
      @(posedge clk_i);
      model_tick();
      #1;
   endtask

   task automatic set_in(input logic mr, input logic [4:0] r_idrt, input logic [4:0] r_rs,
                         input logic [4:0] r_rt, input logic b, input logic j,
                         input logic q, input logic y);
      memread = mr; idrt = r_idrt; rs = r_rs; rt = r_rt;
      br = b; jmp = j; req = q; rdy = y;
   endtask

   task automatic do_reset();
      rst_n_i = 1'b0;
      model_reset();
      step();
      step();
      rst_n_i = 1'b1;
   endtask

   initial begin
      rst_n_i = 1'b0;
      set_in(0, 0, 0, 0, 0, 0, 0, 1);
      model_reset();
      step();
      step();
      rst_n_i = 1'b1;
      repeat (3) step();

      // Asynchronous reset in the middle of a cycle
      #2 rst_n_i = 1'b0;
      model_reset();
      #1 check_all();
      step();
      rst_n_i = 1'b1;
      step();

      // Load-use with a taken branch, then the same with register 0
      set_in(1, 5, 1, 5, 1, 0, 0, 1); step();
      set_in(1, 0, 0, 0, 1, 0, 0, 1); step();
      set_in(0, 0, 0, 0, 0, 0, 0, 1); step();

      // Jump flush
      set_in(0, 0, 0, 0, 0, 1, 0, 1); step();
      set_in(0, 0, 0, 0, 0, 0, 0, 1); step();

      // Four not-ready cycles then ready: t255 releases, t3 halts
      do_reset();
      set_in(1, 7, 7, 0, 1, 0, 1, 0);
      repeat (4) step();
      set_in(1, 7, 7, 0, 1, 0, 1, 1); step();
      set_in(0, 0, 0, 0, 0, 0, 0, 1); repeat (3) step();

      // Memory held not-ready: t3 halts, ready later has no effect
      do_reset();
      set_in(0, 0, 0, 0, 0, 0, 1, 0);
      repeat (6) step();
      set_in(0, 0, 0, 0, 1, 0, 1, 1);
      repeat (4) step();
      do_reset();
      repeat (2) step();

      // Randomized traffic with occasional resets
      for (int i = 0; i < 2000; i++) begin
         set_in(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 5) == 0),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));
         if ($urandom_range(0, 199) == 0) do_reset();
         else step();
      end

      // Continuous load-use stall drives StallCnt into saturation
      do_reset();
      set_in(1, 5, 5, 0, 0, 0, 0, 1);
      repeat (66000) step();
      chk("stall_sat", sc0, 16'hFFFF);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline sequencing controller for the 5-stage core. It owns the write-enable and flush controls for the PC, the IF/ID register and the downstream pipeline registers (ID/EX, EX/MEM, MEM/WB). It resolves three hazard classes:

- load-use stalls,
- branch/jump flushes,
- multi-cycle data-memory waits, with a timeout that halts the pipe.

It also keeps saturating stall and flush performance counters.

## Interface
Parameters:
- MEM_TIMEOUT, 255: max consecutive MEM_WAIT cycles with MemReady_i low before HALT; legal range 1..255.

Ports:
- clk_i  input  1  single clock; all state updates on posedge.
- rst_n_i  input  1  asynchronous, active-low reset.
- IDEX_MemRead_i  input  1  instruction in ID/EX is a load.
- IDEX_Rt_i  input  5  destination register of ID/EX load.
- IFID_Rs_i  input  5  rs of instruction in IF/ID.
- IFID_Rt_i  input  5  rt of instruction in IF/ID.
- Branch_i  input  1  branch resolved taken in ID this cycle.
- Jump_i  input  1  jump decoded in ID this cycle.
- MemReq_i  input  1  EX/MEM stage holds a data-memory access.
- MemReady_i  input  1  data memory completes access this cycle.
- PCWrite_o  output  1  PC register load enable.
- IFIDWrite_o  output  1  IF/ID load enable.
- IFFlush_o  output  1  IF/ID synchronous clear.
- Bubble_o  output  1  zero the control fields entering ID/EX.
- PipeWrite_o  output  1  load enable for ID/EX, EX/MEM, MEM/WB.
- Timeout_o  output  1  sticky; memory timeout occurred (HALT state).
- StallCnt_o  output  16  cycles with PCWrite_o=0, saturating.
- FlushCnt_o  output  16  cycles with IFFlush_o=1, saturating.

## Operation

**States:** RUN, MEM_WAIT, HALT. There is also an internal 8-bit wait_cnt.

**Load-use hazard (LU):**
- LU = IDEX_MemRead_i && IDEX_Rt_i!=0 && (IDEX_Rt_i==IFID_Rs_i || IDEX_Rt_i==IFID_Rt_i).
- Register 0 never causes a stall.

**Memory miss (MISS):** MISS = MemReq_i && !MemReady_i.

**Output decode, priority high→low** (outputs are combinational from state and inputs):
1. HALT: all enables 0, IFFlush_o=0, Bubble_o=0, Timeout_o=1.
2. RUN with MISS, or MEM_WAIT with MemReady_i=0 (freeze): PCWrite_o=IFIDWrite_o=PipeWrite_o=0, IFFlush_o=0, Bubble_o=0.
3. LU: PCWrite_o=0, IFIDWrite_o=0, Bubble_o=1, PipeWrite_o=1, IFFlush_o=0. Branch_i/Jump_i are ignored because the branch operands are not valid yet; the branch re-evaluates next cycle.
4. Branch_i|Jump_i: PCWrite_o=1, IFIDWrite_o=1, IFFlush_o=1, PipeWrite_o=1, Bubble_o=0.
5. Otherwise: PCWrite_o=IFIDWrite_o=PipeWrite_o=1, IFFlush_o=0, Bubble_o=0.

A MEM_WAIT cycle with MemReady_i=1 releases the freeze and decodes via rules 3–5 in that same cycle.

**Transitions:**
- RUN → MEM_WAIT on MISS; wait_cnt←0.
- MEM_WAIT → RUN when MemReady_i=1.
- MEM_WAIT with MemReady_i=0:
  - if wait_cnt==MEM_TIMEOUT-1 → HALT;
  - else wait_cnt←wait_cnt+1.
- HALT is left only by reset.

**Counters:**
- StallCnt_o increments on each posedge where PCWrite_o=0, including freeze, LU and HALT cycles.
- FlushCnt_o increments on each posedge where IFFlush_o=1.
- Both hold at 16'hFFFF; they never wrap.

## Timing
- Reset (rst_n_i low, asynchronous): state=RUN, wait_cnt=0, StallCnt_o=0, FlushCnt_o=0, Timeout_o=0.
  - While rst_n_i is low: PCWrite_o=IFIDWrite_o=PipeWrite_o=0, IFFlush_o=0, Bubble_o=0.
  - Reset asserted mid-MEM_WAIT or in HALT returns to RUN immediately.
- LU stall: exactly 1 cycle. The next cycle sees the load in EX/MEM, so LU is false.
- Flush: IFFlush_o is asserted the same cycle Branch_i/Jump_i is high. The IF/ID register clears at that posedge. Result: 1 bubble.
- Memory freeze length = 1 + number of MEM_WAIT cycles with MemReady_i=0.
  - MemReady_i=1 in the detection cycle means there is no freeze and no state change.
- HALT timing: the HALT state is entered at the posedge ending the MEM_TIMEOUT-th consecutive MEM_WAIT cycle with MemReady_i=0. Timeout_o is high from then on.
- Simultaneous MISS and LU or branch: freeze wins. Branch_i/Jump_i are not latched and must be re-presented by the held ID stage.

## Test plan
1. Reset, then idle inputs → enables 1, IFFlush_o=0, Bubble_o=0, counters 0. Assert rst_n_i mid-cycle → enables drop to 0 immediately, without waiting for a clock edge.
2. IDEX_MemRead_i=1, IDEX_Rt_i=5, IFID_Rt_i=5 for 1 cycle, with Branch_i=1 → PCWrite_o=0, IFIDWrite_o=0, Bubble_o=1, IFFlush_o=0; StallCnt_o=1. Repeat with Rt=0 → no stall.
3. Jump_i=1 for 1 cycle → IFFlush_o=1, PCWrite_o=1; FlushCnt_o=1.
4. MemReq_i=1, MemReady_i=0 for 4 cycles, then MemReady_i=1 → 4 freeze cycles, then release with PipeWrite_o=1 in the ready cycle; StallCnt_o=4; state RUN.
5. MEM_TIMEOUT=3, MemReq_i=1, MemReady_i held 0 → freeze for 4 cycles, HALT after that, Timeout_o=1. Later MemReady_i=1 has no effect; only reset clears Timeout_o.
6. Force stalls for 70000 cycles → StallCnt_o saturates at 16'hFFFF and does not wrap.
